crypto_key_slot_receiver: RTL and testbench

Consumer-side key slot placed in front of each crypto engine (HMAC, AES-CTR, SHA). It accepts an isolated key/valid pair from the secure key distributor and qualifies it for stability. It holds the key steady for the duration of every engine operation, and scrubs it word-by-word on revocation or zeroize. The slot has no bus access; all paths are hardware-only.

---
 rtl/crypto_key_slot_receiver.sv | 182 ++++++++++++++++++
 tb/tb_crypto_key_slot_receiver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_key_slot_receiver.sv
// Consumer-side key slot: qualifies a distributed key for stability, holds it
// steady across engine operations and scrubs it word-by-word on revoke/zeroize.
module crypto_key_slot_receiver #(
  parameter int KEY_WIDTH     = 256,
  parameter int WORD_WIDTH    = 32,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 key_in_valid,
  input  logic                 zeroize,
  input  logic                 op_start,
  input  logic                 op_done,
  input  logic                 fault_clear,
  output logic [KEY_WIDTH-1:0] engine_key,
  output logic                 engine_key_valid,
  output logic                 op_grant,
  output logic                 key_ready,
  output logic                 scrub_busy,
  output logic                 key_fault,
  output logic [3:0]           key_epoch
);

  localparam int NUM_WORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam logic [3:0]       STABLE_CNT = 4'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_QUALIFY,
    ST_LOADED,
    ST_IN_USE,
    ST_SCRUB
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_reg_q, key_reg_d;
  logic [KEY_WIDTH-1:0] snapshot_q, snapshot_d;
  logic [3:0]           count_q, count_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic                 pending_revoke_q, pending_revoke_d;
  logic                 key_fault_q, key_fault_d;
  logic [3:0]           key_epoch_q, key_epoch_d;

  logic revoke;
  logic key_nonzero;
  logic fault_set;

  assign revoke      = !key_in_valid || (key_in != key_reg_q);
  assign key_nonzero = |key_in;

  always_comb begin
    state_d          = state_q;
    key_reg_d        = key_reg_q;
    snapshot_d       = snapshot_q;
    count_d          = count_q;
    word_idx_d       = word_idx_q;
    pending_revoke_d = pending_revoke_q;
    key_epoch_d      = key_epoch_q;
    fault_set        = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (op_start || op_done) fault_set = 1'b1;
        // Zeroize while empty has nothing to scrub; it only blocks qualification.
        if (!zeroize && key_in_valid && key_nonzero) begin
          if (STABLE_CYCLES == 1) begin
            key_reg_d   = key_in;
            key_epoch_d = key_epoch_q + 4'd1;
            state_d     = ST_LOADED;
          end else begin
            snapshot_d = key_in;
            count_d    = 4'd1;
            state_d    = ST_QUALIFY;
          end
        end
      end

      ST_QUALIFY: begin
        if (op_start || op_done) fault_set = 1'b1;
        if (zeroize) begin
          state_d = ST_SCRUB;
        end else if (key_in_valid && key_nonzero) begin
          if (key_in == snapshot_q) begin
            if (count_q + 4'd1 == STABLE_CNT) begin
              key_reg_d   = snapshot_q;
              key_epoch_d = key_epoch_q + 4'd1;
              count_d     = '0;
              state_d     = ST_LOADED;
            end else begin
              count_d = count_q + 4'd1;
            end
          end else begin
            snapshot_d = key_in;
            count_d    = 4'd1;
          end
        end else begin
          snapshot_d = '0;
          count_d    = '0;
          state_d    = ST_EMPTY;
        end
      end

      ST_LOADED: begin
        if (op_done) fault_set = 1'b1;
        if (zeroize || revoke) begin
          state_d = ST_SCRUB;
        end else if (op_start) begin
          state_d = ST_IN_USE;
        end
      end

      ST_IN_USE: begin
        if (op_start) fault_set = 1'b1;
        if (zeroize) begin
          fault_set = 1'b1;
          state_d   = ST_SCRUB;
        end else begin
          if (revoke) begin
            pending_revoke_d = 1'b1;
            fault_set        = 1'b1;
          end
          if (op_done) begin
            state_d = (pending_revoke_q || revoke) ? ST_SCRUB : ST_LOADED;
          end
        end
      end

      ST_SCRUB: begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
          if (w == 32'(word_idx_q)) key_reg_d[w*WORD_WIDTH +: WORD_WIDTH] = '0;
        end
        snapshot_d       = '0;
        count_d          = '0;
        pending_revoke_d = 1'b0;
        if (word_idx_q == LAST_IDX) begin
          word_idx_d = '0;
          state_d    = ST_EMPTY;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
        end
      end

      default: state_d = ST_EMPTY;
    endcase

    key_fault_d = fault_set ? 1'b1 : (fault_clear ? 1'b0 : key_fault_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_EMPTY;
      key_reg_q        <= '0;
      snapshot_q       <= '0;
      count_q          <= '0;
      word_idx_q       <= '0;
      pending_revoke_q <= 1'b0;
      key_fault_q      <= 1'b0;
      key_epoch_q      <= '0;
    end else begin
      state_q          <= state_d;
      key_reg_q        <= key_reg_d;
      snapshot_q       <= snapshot_d;
      count_q          <= count_d;
      word_idx_q       <= word_idx_d;
      pending_revoke_q <= pending_revoke_d;
      key_fault_q      <= key_fault_d;
      key_epoch_q      <= key_epoch_d;
    end
  end

  assign engine_key_valid = (state_q == ST_LOADED) || (state_q == ST_IN_USE);
  assign engine_key       = engine_key_valid ? key_reg_q : '0;
  assign key_ready        = (state_q == ST_LOADED);
  assign scrub_busy       = (state_q == ST_SCRUB);
  assign key_fault        = key_fault_q;
  assign key_epoch        = key_epoch_q;
  assign op_grant         = op_start && (state_q == ST_LOADED) && !revoke && !zeroize;

endmodule

// File: tb/tb_crypto_key_slot_receiver.sv
// Scoreboard bench for crypto_key_slot_receiver: a behavioural slot model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_crypto_key_slot_receiver;

  localparam int KW = 256;
  localparam int WW = 32;
  localparam int SC = 2;
  localparam int NW = KW / WW;

  logic          clock = 1'b0;
  logic          reset;
  logic [KW-1:0] key_in;
  logic          key_in_valid, zeroize, op_start, op_done, fault_clear;
  logic [KW-1:0] engine_key;
  logic          engine_key_valid, op_grant, key_ready, scrub_busy, key_fault;
  logic [3:0]    key_epoch;

  crypto_key_slot_receiver #(
    .KEY_WIDTH(KW), .WORD_WIDTH(WW), .STABLE_CYCLES(SC)
  ) dut (
    .clock(clock), .reset(reset), .key_in(key_in), .key_in_valid(key_in_valid),
    .zeroize(zeroize), .op_start(op_start), .op_done(op_done),
    .fault_clear(fault_clear), .engine_key(engine_key),
    .engine_key_valid(engine_key_valid), .op_grant(op_grant),
    .key_ready(key_ready), .scrub_busy(scrub_busy), .key_fault(key_fault),
    .key_epoch(key_epoch)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [KW-1:0] key;
    logic          kv, grant, ready, busy, fault;
    logic [3:0]    epoch;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural slot model.
  typedef enum {M_EMPTY, M_QUAL, M_LOADED, M_BUSY, M_SCRUB} mstate_t;
  mstate_t       m_st;
  logic [KW-1:0] m_key, m_snap;
  int            m_run, m_scrub_left, m_epoch;
  bit            m_pending, m_fault;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_EMPTY; m_key = '0; m_snap = '0; m_run = 0;
    m_scrub_left = 0; m_epoch = 0; m_pending = 0; m_fault = 0;
  endtask

  task automatic start_scrub();
    m_st = M_SCRUB; m_scrub_left = NW; m_pending = 0;
  endtask

  task automatic load(input logic [KW-1:0] k);
    m_key = k; m_st = M_LOADED; m_epoch = (m_epoch + 1) % 16;
  endtask

  task automatic model_step(input bit v, input logic [KW-1:0] k, input bit z,
                            input bit s, input bit d, input bit fc);
    bit rev, fset;
    rev  = !v || (k != m_key);
    fset = 0;
    case (m_st)
      M_EMPTY: begin
        if (s || d) fset = 1;
        if (!z && v && k != 0) begin
          if (SC == 1) load(k);
          else begin m_snap = k; m_run = 1; m_st = M_QUAL; end
        end
      end
      M_QUAL: begin
        if (s || d) fset = 1;
        if (z) start_scrub();
        else if (v && k != 0) begin
          if (k == m_snap) begin
            m_run++;
            if (m_run == SC) load(m_snap);
          end else begin m_snap = k; m_run = 1; end
        end else begin m_snap = '0; m_st = M_EMPTY; end
      end
      M_LOADED: begin
        if (d) fset = 1;
        if (z || rev) start_scrub();
        else if (s) m_st = M_BUSY;
      end
      M_BUSY: begin
        if (s) fset = 1;
        if (z) begin fset = 1; start_scrub(); end
        else begin
          if (rev) begin m_pending = 1; fset = 1; end
          if (d) begin
            if (m_pending) start_scrub();
            else m_st = M_LOADED;
          end
        end
      end
      M_SCRUB: begin
        m_scrub_left--;
        if (m_scrub_left == 0) begin m_st = M_EMPTY; m_key = '0; m_snap = '0; end
      end
      default: ;
    endcase
    if (fset) m_fault = 1;
    else if (fc) m_fault = 0;
  endtask

  // One stimulus cycle: drive, predict this cycle's outputs, advance the model.
  task automatic cyc(input bit v, input logic [KW-1:0] k, input bit z,
                     input bit s, input bit d, input bit fc);
    exp_t e;
    bit   rev;
    @(posedge clock); #1;
    key_in_valid = v; key_in = k; zeroize = z;
    op_start = s; op_done = d; fault_clear = fc;
    rev     = !v || (k != m_key);
    e.kv    = (m_st == M_LOADED) || (m_st == M_BUSY);
    e.key   = e.kv ? m_key : '0;
    e.ready = (m_st == M_LOADED);
    e.busy  = (m_st == M_SCRUB);
    e.fault = m_fault;
    e.epoch = 4'(m_epoch);
    e.grant = s && (m_st == M_LOADED) && !rev && !z;
    exp_q.push_back(e);
    model_step(v, k, z, s, d, fc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_engine_key"}, engine_key, '0);
    chk({tag, "_outs"}, KW'({engine_key_valid, op_grant, key_ready, scrub_busy, key_fault}), '0);
    chk({tag, "_epoch"}, KW'(key_epoch), '0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clock); #2;
    reset = 1'b1;
    key_in_valid = 0; key_in = '0; zeroize = 0; op_start = 0; op_done = 0; fault_clear = 0;
    #1;
    chk_all_zero(tag);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("engine_key", engine_key, e.key);
        chk("engine_key_valid", KW'(engine_key_valid), KW'(e.kv));
        chk("op_grant", KW'(op_grant), KW'(e.grant));
        chk("key_ready", KW'(key_ready), KW'(e.ready));
        chk("scrub_busy", KW'(scrub_busy), KW'(e.busy));
        chk("key_fault", KW'(key_fault), KW'(e.fault));
        chk("key_epoch", KW'(key_epoch), KW'(e.epoch));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [KW-1:0] ka, k1, k2, k3, k4, cur;
    logic [KW-1:0] pool[4];
    ka = {8{32'hA5A5A5A5}};
    k1 = {8{32'h11111111}};
    k2 = {8{32'h22222222}};
    k3 = {8{32'h33333333}};
    k4 = {8{32'h44444444}};

    reset = 1'b1;
    key_in_valid = 0; key_in = '0; zeroize = 0; op_start = 0; op_done = 0; fault_clear = 0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Load A5, run an op, revoke mid-op, then full scrub.
    repeat (3) cyc(1, ka, 0, 0, 0, 0);
    cyc(1, ka, 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 1, 0);
    idle(NW + 2);

    // Zero key never qualifies.
    repeat (4) cyc(1, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1);

    // Qualification restart on key change.
    cyc(1, k1, 0, 0, 0, 0);
    repeat (4) cyc(1, k2, 0, 0, 0, 0);

    // Zeroize during an op, then clear the fault once scrub is over.
    cyc(1, k2, 0, 1, 0, 0);
    cyc(1, k2, 0, 0, 0, 0);
    cyc(1, k2, 1, 0, 0, 0);
    idle(NW + 1);
    cyc(0, '0, 0, 0, 0, 1);

    // op_start coincident with key change: no grant, scrub.
    repeat (3) cyc(1, k3, 0, 0, 0, 0);
    cyc(1, k4, 0, 1, 0, 0);
    idle(NW + 2);

    // Held zeroize keeps the slot empty.
    repeat (NW + 4) cyc(1, k3, 1, 0, 0, 0);

    // 16 loads from reset wrap the epoch back to 0.
    do_reset("reset2");
    for (int i = 0; i < 16; i++) begin
      cur = {8{32'(i + 1)}};
      repeat (2) cyc(1, cur, 0, 0, 0, 0);
      idle(NW + 2);
    end
    chk("epoch_wrap", KW'(key_epoch), '0);

    // op_done while empty raises a fault.
    cyc(0, '0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 0);

    // Async reset in the middle of a scrub.
    repeat (3) cyc(1, ka, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    do_reset("reset_mid_scrub");

    // Randomised traffic with a sticky key to reach loaded/in-use often.
    pool[0] = '0; pool[1] = ka; pool[2] = k1; pool[3] = k2;
    cur = ka;
    for (int i = 0; i < 3000; i++) begin
      bit v, z, s, d, fc;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          cur = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        else
          cur = pool[$urandom_range(0, 3)];
      end
      v  = ($urandom_range(0, 15) != 0);
      z  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 3) == 0);
      fc = ($urandom_range(0, 15) == 0);
      cyc(v, cur, z, s, d, fc);
    end
    idle(2);
    @(negedge clock); #1;
    chk("scoreboard_drained", KW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
